// File: rtl/sim_mmio_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sim_mmio_monitor                                           |
// | Description : Simulation-control peripheral on the srv32 data-write path.|
// |               Decodes PUTC/EXIT MMIO writes (withheld from RAM), buffers |
// |               console characters per channel and streams them out        |
// |               round-robin, runs a PC-stall watchdog and a RAM range      |
// |               check, and reports one termination cause once every        |
// |               console character has left the block.                      |
// | Ports       : clk, resetb (async, active-low)                            |
// |               req_valid/addr/wdata/wstrb in; req_hit, req_stall out      |
// |               pc_valid/pc in (watchdog samples)                          |
// |               tx_valid/tx_ch/tx_data out, tx_ready in (console stream)   |
// |               done/status/exit_code/err_addr out (termination report)    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sim_mmio_monitor #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          NCH        = 2,
  parameter int          FIFO_DEPTH = 16,
  parameter int          TIMEOUT    = 100,
  parameter int unsigned MEM_LIMIT  = 262144
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        req_hit,
  output logic        req_stall,
  input  logic        pc_valid,
  input  logic [31:0] pc,
  output logic        tx_valid,
  output logic [1:0]  tx_ch,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        done,
  output logic [1:0]  status,
  output logic [31:0] exit_code,
  output logic [31:0] err_addr
);

  localparam int          AW          = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] C_DEPTH     = FIFO_DEPTH[AW:0];
  localparam logic [AW:0] C_PTR_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [16:0] C_TIMEOUT   = TIMEOUT[16:0];
  localparam logic [31:0] C_MEM_LIMIT = MEM_LIMIT;
  localparam logic [31:0] C_EXIT_ADDR = BASE_ADDR + 32'h2C;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  logic                    w_run, w_accept, w_exit_hit, w_load, w_found;
  logic                    w_exit_ev, w_range_ev, w_to_ev, w_all_empty, w_set_done;
  logic [NCH-1:0]          w_putc_hit, w_push, w_full, w_nonempty, w_avail, w_take;
  logic [NCH-1:0][7:0]     w_data_sel;
  logic [3:0]              w_avail4;
  logic [1:0]              w_sel, w_idx;
  logic [7:0]              w_out_data;

  logic                    r_tx_valid;
  logic [1:0]              r_tx_ch, r_last;
  logic [7:0]              r_tx_data;
  logic                    r_done;
  logic [1:0]              r_status;
  logic [31:0]             r_exit_code, r_err_addr;

  logic [16:0]             r_wd_cnt, w_wd_inc;
  logic [31:0]             r_last_pc;
  logic                    r_pc_seen, w_pc_same;

  logic                    w_unused;
  assign w_unused = &{1'b0, req_wstrb[3:1]};

  assign w_run      = (r_state == ST_RUN);
  assign w_exit_hit = (req_addr == C_EXIT_ADDR);
  assign req_hit    = (|w_putc_hit) || w_exit_hit;
  assign req_stall  = req_valid && w_run && (|(w_putc_hit & w_full));
  assign w_accept   = req_valid && !req_stall;
  // Output stage is free when empty or being consumed this cycle.
  assign w_load     = !r_tx_valid || tx_ready;

  // ---------------------------------------------------------------------
  // Per-channel FIFOs. Occupancy counts the output stage too, so a channel
  // holds at most FIFO_DEPTH characters in total. An empty FIFO whose
  // channel wins arbitration passes the incoming character straight to the
  // output stage without being written.
  // ---------------------------------------------------------------------
  for (genvar n = 0; n < NCH; n++) begin : g_ch
    logic [AW:0] r_wr_ptr, r_rd_ptr, w_count, w_occ;
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic        w_out_here, w_wr, w_pop;

    assign w_putc_hit[n] = (req_addr == (BASE_ADDR + 32'h1C + 32'(n) * 32'h40));
    assign w_count       = r_wr_ptr - r_rd_ptr;
    assign w_nonempty[n] = (w_count != '0);
    assign w_out_here    = r_tx_valid && (r_tx_ch == 2'(n));
    assign w_occ         = w_count + {{AW{1'b0}}, w_out_here};
    assign w_full[n]     = (w_occ >= C_DEPTH);
    assign w_push[n]     = w_run && w_accept && w_putc_hit[n] && req_wstrb[0];
    assign w_avail[n]    = w_nonempty[n] || w_push[n];
    assign w_take[n]     = w_load && w_found && (w_sel == 2'(n));
    assign w_pop         = w_take[n] && w_nonempty[n];
    assign w_wr          = w_push[n] && !(w_take[n] && !w_nonempty[n]);
    assign w_data_sel[n] = !w_take[n]    ? 8'h00 :
                           w_nonempty[n] ? r_mem[r_rd_ptr[AW-1:0]] : req_wdata[7:0];

    always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr)  r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
        if (w_pop) r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
    end

    always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= req_wdata[7:0];
    end
  end

  // Round-robin: search starts at the channel after the last grant.
  assign w_avail4 = 4'(w_avail);
  always_comb begin
    w_found = 1'b0;
    w_sel   = 2'd0;
    w_idx   = 2'd0;
    for (int i = 1; i <= NCH; i++) begin
      w_idx = 2'((int'(r_last) + i) % NCH);
      if (!w_found && w_avail4[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_comb begin
    w_out_data = 8'h00;
    for (int n = 0; n < NCH; n++) w_out_data = w_out_data | w_data_sel[n];
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_tx_valid <= 1'b0;
      r_tx_ch    <= 2'd0;
      r_tx_data  <= 8'h00;
      r_last     <= 2'd0;
    end else if (w_load) begin
      r_tx_valid <= w_found;
      if (w_found) begin
        r_tx_ch   <= w_sel;
        r_tx_data <= w_out_data;
        r_last    <= w_sel;
      end
    end
  end

  // Watchdog: the first sample after reset only records the PC.
  assign w_pc_same = r_pc_seen && (pc == r_last_pc);
  assign w_wd_inc  = r_wd_cnt + 17'd1;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_wd_cnt  <= '0;
      r_last_pc <= '0;
      r_pc_seen <= 1'b0;
    end else if (w_run && pc_valid) begin
      r_wd_cnt  <= w_pc_same ? w_wd_inc : 17'd0;
      r_last_pc <= pc;
      r_pc_seen <= 1'b1;
    end
  end

  assign w_exit_ev   = w_run && w_accept && w_exit_hit;
  assign w_range_ev  = w_run && w_accept && !req_hit && (req_addr >= C_MEM_LIMIT);
  assign w_to_ev     = w_run && pc_valid && w_pc_same && (w_wd_inc > C_TIMEOUT);
  assign w_all_empty = !(|w_nonempty) && !r_tx_valid;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) r_state <= ST_RUN;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_set_done   = 1'b0;
    case (r_state)
      ST_RUN:   if (w_exit_ev || w_range_ev || w_to_ev) w_state_next = ST_DRAIN;
      ST_DRAIN: if (w_all_empty) begin
                  w_state_next = ST_DONE;
                  w_set_done   = 1'b1;
                end
      default:  w_state_next = ST_DONE;
    endcase
  end

  // Cause registers only load while running, so the first cause sticks.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_done      <= 1'b0;
      r_status    <= 2'd0;
      r_exit_code <= '0;
      r_err_addr  <= '0;
    end else begin
      if (w_exit_ev) begin
        r_status    <= 2'd1;
        r_exit_code <= req_wdata;
      end else if (w_range_ev) begin
        r_status    <= 2'd3;
        r_err_addr  <= req_addr;
      end else if (w_to_ev) begin
        r_status    <= 2'd2;
      end
      if (w_set_done) r_done <= 1'b1;
    end
  end

  assign tx_valid  = r_tx_valid;
  assign tx_ch     = r_tx_ch;
  assign tx_data   = r_tx_data;
  assign done      = r_done;
  assign status    = r_status;
  assign exit_code = r_exit_code;
  assign err_addr  = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_sim_mmio_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sim_mmio_monitor                                        |
// | Description : Self-checking bench for sim_mmio_monitor: a vector table   |
// |               for console decode/streaming/round-robin plus sequences for|
// |               FIFO-full stall, EXIT drain, range error, watchdog and     |
// |               asynchronous reset.                                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sim_mmio_monitor;

  localparam logic [31:0] CH0   = 32'h8000_001C;
  localparam logic [31:0] CH1   = 32'h8000_005C;
  localparam logic [31:0] CH2   = 32'h8000_009C;
  localparam logic [31:0] EXITA = 32'h8000_002C;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        req_hit, req_stall;
  logic        pc_valid = 1'b0;
  logic [31:0] pc = '0;
  logic        tx_valid;
  logic [1:0]  tx_ch;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        done;
  logic [1:0]  status;
  logic [31:0] exit_code, err_addr;

  sim_mmio_monitor #(
    .BASE_ADDR (32'h8000_0000),
    .NCH       (2),
    .FIFO_DEPTH(16),
    .TIMEOUT   (100),
    .MEM_LIMIT (262144)
  ) dut (
    .clk(clk), .resetb(resetb),
    .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_hit(req_hit), .req_stall(req_stall),
    .pc_valid(pc_valid), .pc(pc),
    .tx_valid(tx_valid), .tx_ch(tx_ch), .tx_data(tx_data), .tx_ready(tx_ready),
    .done(done), .status(status), .exit_code(exit_code), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int got     = 0;

  typedef struct {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic        hit;
    logic        stall;
    logic        txv;
    logic [1:0]  ch;
    logic [7:0]  data;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic v, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic r, input logic h,
                              input logic st, input logic tv, input logic [1:0] c,
                              input logic [7:0] td);
    vec_t x;
    x.valid = v; x.addr = a; x.wdata = d; x.wstrb = s; x.ready = r;
    x.hit = h; x.stall = st; x.txv = tv; x.ch = c; x.data = td;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    req_valid = v; req_addr = a; req_wdata = d; req_wstrb = s;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    tx_ready = 1'b0;
    pc_valid = 1'b0;
    pc       = '0;
    @(negedge clk);
    resetb = 1'b0;
    tick();
    @(negedge clk);
    check("rst_done", done, 0);
    check("rst_status", status, 0);
    check("rst_exit_code", exit_code, 0);
    check("rst_err_addr", err_addr, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_ch", tx_ch, 0);
    check("rst_tx_data", tx_data, 0);
    resetb = 1'b1;
    tick();
  endtask

  task automatic sample_tx(input logic [7:0] base);
    if (tx_valid && tx_ready) begin
      check("tx_order", {24'd0, tx_data}, {24'd0, base + 8'(got)});
      got++;
    end
  endtask

  initial begin
    // --- vector table: "Hi", RAM write, dropped byte, queued round-robin ---
    vecs[0]  = mk(1, CH0,          32'h48, 4'h1, 1, 1, 0, 0, 0, 8'h00);
    vecs[1]  = mk(1, CH0,          32'h69, 4'h1, 1, 1, 0, 1, 0, 8'h48);
    vecs[2]  = mk(0, 32'h0,        32'h00, 4'h0, 1, 0, 0, 1, 0, 8'h69);
    vecs[3]  = mk(1, 32'h100,      32'hFF, 4'hF, 1, 0, 0, 0, 0, 8'h00);
    vecs[4]  = mk(1, CH0,          32'h58, 4'h2, 1, 1, 0, 0, 0, 8'h00);
    vecs[5]  = mk(0, CH2,          32'h00, 4'h0, 1, 0, 0, 0, 0, 8'h00);
    vecs[6]  = mk(1, CH0,          32'h61, 4'h1, 0, 1, 0, 0, 0, 8'h00);
    vecs[7]  = mk(1, CH0,          32'h63, 4'h1, 0, 1, 0, 1, 0, 8'h61);
    vecs[8]  = mk(1, CH0,          32'h65, 4'h1, 0, 1, 0, 1, 0, 8'h61);
    vecs[9]  = mk(1, CH1,          32'h62, 4'h1, 0, 1, 0, 1, 0, 8'h61);
    vecs[10] = mk(1, CH1,          32'h64, 4'h1, 0, 1, 0, 1, 0, 8'h61);
    vecs[11] = mk(1, CH1,          32'h66, 4'h1, 0, 1, 0, 1, 0, 8'h61);
    vecs[12] = mk(0, 32'h0,        32'h00, 4'h0, 1, 0, 0, 1, 0, 8'h61);
    vecs[13] = mk(0, 32'h0,        32'h00, 4'h0, 1, 0, 0, 1, 1, 8'h62);
    vecs[14] = mk(0, 32'h0,        32'h00, 4'h0, 1, 0, 0, 1, 0, 8'h63);
    vecs[15] = mk(0, 32'h0,        32'h00, 4'h0, 1, 0, 0, 1, 1, 8'h64);
    vecs[16] = mk(0, 32'h0,        32'h00, 4'h0, 1, 0, 0, 1, 0, 8'h65);
    vecs[17] = mk(0, 32'h0,        32'h00, 4'h0, 1, 0, 0, 1, 1, 8'h66);
    vecs[18] = mk(0, 32'h0,        32'h00, 4'h0, 1, 0, 0, 0, 0, 8'h00);

    do_reset();
    for (int k = 0; k < 19; k++) begin
      drive(vecs[k].valid, vecs[k].addr, vecs[k].wdata, vecs[k].wstrb);
      tx_ready = vecs[k].ready;
      @(negedge clk);
      check($sformatf("vec%0d_hit", k), req_hit, vecs[k].hit);
      check($sformatf("vec%0d_stall", k), req_stall, vecs[k].stall);
      check($sformatf("vec%0d_tx_valid", k), tx_valid, vecs[k].txv);
      if (vecs[k].txv) begin
        check($sformatf("vec%0d_tx_ch", k), tx_ch, vecs[k].ch);
        check($sformatf("vec%0d_tx_data", k), tx_data, vecs[k].data);
      end
      check($sformatf("vec%0d_status", k), status, 0);
      tick();
    end
    idle();

    // --- FIFO full: 17 writes into a 16-deep channel with the sink stalled ---
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, CH0, 32'h41 + i, 4'h1);
      @(negedge clk);
      check("fill_stall", req_stall, 0);
      tick();
    end
    drive(1'b1, CH0, 32'h51, 4'h1);
    @(negedge clk);
    check("full_stall", req_stall, 1);
    check("full_tx_valid", tx_valid, 1);
    check("full_tx_data", tx_data, 32'h41);
    tick();
    @(negedge clk);
    check("full_stall_hold", req_stall, 1);
    check("full_tx_stable", tx_data, 32'h41);
    tick();
    tx_ready = 1'b1;
    got = 0;
    @(negedge clk);
    check("pop_cycle_stall", req_stall, 1);
    sample_tx(8'h41);
    tick();
    @(negedge clk);
    check("after_pop_stall", req_stall, 0);
    sample_tx(8'h41);
    tick();
    idle();
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      sample_tx(8'h41);
      tick();
    end
    @(negedge clk);
    check("full_all_chars", got, 17);
    check("full_tx_idle", tx_valid, 0);

    // --- EXIT with characters pending: done waits for the drain ---
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, CH0, 32'h77 + i, 4'h1);
      tick();
    end
    drive(1'b1, EXITA, 32'h5, 4'hF);
    @(negedge clk);
    check("exit_hit", req_hit, 1);
    check("exit_stall", req_stall, 0);
    check("exit_pre_status", status, 0);
    tick();
    drive(1'b1, CH0, 32'h51, 4'h1);
    @(negedge clk);
    check("exit_status", status, 1);
    check("exit_code", exit_code, 5);
    check("exit_done_early", done, 0);
    check("drain_putc_stall", req_stall, 0);
    check("drain_putc_hit", req_hit, 1);
    tick();
    drive(1'b1, EXITA, 32'h9, 4'hF);
    tick();
    idle();
    @(negedge clk);
    check("exit_code_held", exit_code, 5);
    check("exit_done_wait", done, 0);
    check("exit_tx_head", tx_data, 32'h77);
    tick();
    tx_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) break;
      sample_tx(8'h77);
      tick();
    end
    check("exit_done", done, 1);
    check("exit_chars", got, 4);
    check("exit_status_done", status, 1);
    drive(1'b1, CH0, 32'h52, 4'h1);
    tick();
    idle();
    tick();
    @(negedge clk);
    check("done_putc_ignored", tx_valid, 0);
    check("done_held", done, 1);

    // --- range check: last legal word, then first illegal byte address ---
    do_reset();
    drive(1'b1, 32'h0003_FFFC, 32'h1, 4'hF);
    tick();
    drive(1'b1, 32'h0004_0000, 32'h2, 4'hF);
    @(negedge clk);
    check("range_ok_status", status, 0);
    check("range_hit", req_hit, 0);
    tick();
    drive(1'b1, 32'h0005_0000, 32'h3, 4'hF);
    @(negedge clk);
    check("range_status", status, 3);
    check("range_err_addr", err_addr, 32'h0004_0000);
    check("range_done_early", done, 0);
    tick();
    idle();
    @(negedge clk);
    check("range_done", done, 1);
    check("range_err_held", err_addr, 32'h0004_0000);
    check("range_exit_code", exit_code, 0);

    // --- watchdog: constant PC fires on the 102nd sample ---
    do_reset();
    pc_valid = 1'b1;
    pc       = 32'h100;
    for (int k = 1; k <= 102; k++) begin
      @(negedge clk);
      if (k == 102) check("wd_before_fire", status, 0);
      tick();
    end
    @(negedge clk);
    check("wd_status", status, 2);
    tick();
    @(negedge clk);
    check("wd_done", done, 1);
    check("wd_exit_code", exit_code, 0);

    // --- watchdog: PC change at sample 50 restarts the count ---
    do_reset();
    pc_valid = 1'b1;
    for (int k = 1; k <= 151; k++) begin
      pc = (k < 50) ? 32'h100 : 32'h200;
      @(negedge clk);
      if (k == 102) check("wd_restart_102", status, 0);
      if (k == 151) check("wd_restart_150", status, 0);
      tick();
    end
    @(negedge clk);
    check("wd_restart_fire", status, 2);
    pc_valid = 1'b0;

    // --- asynchronous reset mid-operation discards buffered characters ---
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, CH1, 32'h30 + i, 4'h1);
      tick();
    end
    idle();
    @(negedge clk);
    check("pre_rst_tx_valid", tx_valid, 1);
    check("pre_rst_tx_ch", tx_ch, 1);
    resetb = 1'b0;
    #1;
    check("async_rst_tx_valid", tx_valid, 0);
    check("async_rst_tx_ch", tx_ch, 0);
    tick();
    @(negedge clk);
    resetb   = 1'b1;
    tx_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clk);
      check("post_rst_no_tx", tx_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sim_mmio_monitor.md
Name: sim_mmio_monitor

Overview:
Synthesizable simulation-control peripheral on the data-memory write path of the srv32 core.
- Decodes console-output (PUTC) and EXIT writes, and withholds them from RAM.
- Buffers console characters per channel in FIFOs and drains them over a valid/ready stream.
- Runs a PC-stall watchdog and a memory-range check.
- Reports a single termination cause and exit code after all console FIFOs have drained.

Parameters:
BASE_ADDR, 32'h80000000, MMIO base address
NCH, 2, console channels (1..4)
FIFO_DEPTH, 16, entries per channel FIFO (power of 2, >=2)
TIMEOUT, 100, watchdog threshold in unchanged-PC samples (<=65535)
MEM_LIMIT, 262144, RAM size in bytes (power of 2); non-MMIO writes at or above it are range errors

Ports:
clk  in  1  clock
resetb  in  1  reset, asynchronous, active-low
req_valid  in  1  data write request
req_addr  in  32  byte address
req_wdata  in  32  write data
req_wstrb  in  4  byte strobes
req_hit  out  1  combinational: address is MMIO, so RAM write must be suppressed
req_stall  out  1  combinational: request not accepted this cycle
pc_valid  in  1  pc sample valid
pc  in  32  current fetch PC
tx_valid  out  1  character available
tx_ch  out  2  source channel of tx_data
tx_data  out  8  character
tx_ready  in  1  sink accepts character
done  out  1  simulation terminated, all FIFOs empty
status  out  2  0 running, 1 exit, 2 timeout, 3 range error
exit_code  out  32  EXIT data, or 0 for other causes
err_addr  out  32  address of the first out-of-range write

Behaviour:
- Reset values: done=0, status=0, exit_code=0, err_addr=0, tx_valid=0, tx_ch=0, tx_data=0. FIFOs empty, watchdog count 0, arbiter pointer 0, state RUN.
- Address map:
  - PUTC for channel n: BASE_ADDR+0x1C+0x40*n, for n<NCH.
  - EXIT: BASE_ADDR+0x2C.
  - req_hit=1 for these addresses only; it is independent of state.
- Acceptance: a request is accepted when req_valid && !req_stall.
  - req_stall=1 only for a PUTC write in RUN whose channel FIFO is full.
  - A pop in the same cycle does not free the slot; the push is accepted the next cycle.
- PUTC in RUN: pushes req_wdata[7:0] only if req_wstrb[0]=1; otherwise the write is accepted and dropped.
- States:
  - RUN: normal operation.
  - DRAIN: cause latched; all MMIO writes and range checks are ignored; FIFOs keep draining. Moves to DONE in the first cycle all FIFOs are empty, with done=1 registered in that transition.
  - DONE: terminal until reset; done, status, exit_code and err_addr are held.
- Termination causes, checked only in RUN; the first cause latched wins:
  - EXIT write: status=1, exit_code=req_wdata.
  - Range error: non-MMIO write with req_addr>=MEM_LIMIT; status=3, err_addr=req_addr.
  - Timeout: status=2. Watchdog samples on pc_valid: count+1 if pc equals the last sample, else count is cleared. Fires when count exceeds TIMEOUT; the first sample always clears.
  - Same-cycle priority: EXIT > range > timeout.
- Output stream:
  - Round-robin over non-empty FIFOs, starting after the last granted channel.
  - Output stage is registered: a character pushed in cycle t is visible at tx_valid no earlier than t+1.
  - tx_ch/tx_data are stable while tx_valid && !tx_ready.
  - Transfer occurs on tx_valid && tx_ready. The next character may appear the following cycle, giving 1 char/cycle throughput.
- FIFO pointers wrap modulo FIFO_DEPTH, with an extra bit for full/empty detection. Count never exceeds FIFO_DEPTH.
- Reset asserted mid-operation: all state returns to reset values immediately; buffered characters are lost.

Test Plan:
- Write 'H','i' to ch0 (0x8000001C), tx_ready=1 -> tx shows ch0 'H' then 'i' on consecutive cycles, first char 1 cycle after push; req_hit=1 on both writes.
- Hold tx_ready=0, write 17 chars to ch0 (depth 16) -> 17th write sees req_stall=1 until a pop frees a slot; all 17 chars emerge in order with no loss; tx_data stable while stalled.
- Interleave 3 chars each on ch0 and ch1 (0x8000005C), tx_ready=1 -> output alternates ch0/ch1 in round-robin order.
- Queue 4 chars on ch0 with tx_ready=0, then EXIT with data 0x5 -> status=1, exit_code=5, done stays 0 until tx_ready=1 drains the 4 chars, then done=1; later PUTC ignored.
- Write to 0x00040000 with MEM_LIMIT=262144 -> status=3, err_addr=0x00040000, req_hit=0, done=1 next cycle with FIFOs empty.
- Hold pc constant with pc_valid=1 -> status=2 after 102 samples (first sample clears, fires when count exceeds 100); a PC change at sample 50 restarts the count.
